// File: rtl/game_state_controller.sv
// game_state_controller
// Game-flow FSM. It produces mutually exclusive phase flags for the drawing
// blocks, tracks remaining lives, and times the crash freeze and the
// win/lose hold in video frames.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a start press; all phase flags low
// PLAY  | game running
// CRASH | non-fatal crash; motion frozen for CRASH_FRAMES frames
// WIN   | finish line reached; held at least RESULT_FRAMES frames
// LOSE  | lives or fuel exhausted; held at least RESULT_FRAMES frames
//
// Ports:
//   clk, resetN            pixel clock, async active-low reset
//   startOfFrame           one-cycle pulse per video frame
//   startKey               debounced start key level
//   crash, finishLine      one-cycle event pulses from collision logic
//   fuelEmpty              fuel exhausted level
//   gameReq/winReq/loseReq registered phase flags
//   crashFreeze            high while in CRASH
//   newGame                one-cycle pulse when a game starts
//   livesLeft              remaining lives
module game_state_controller #(
    parameter int LIVES         = 3,
    parameter int CRASH_FRAMES  = 60,
    parameter int RESULT_FRAMES = 120
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic       startKey,
    input  logic       crash,
    input  logic       finishLine,
    input  logic       fuelEmpty,
    output logic       gameReq,
    output logic       winReq,
    output logic       loseReq,
    output logic       crashFreeze,
    output logic       newGame,
    output logic [1:0] livesLeft
);

    typedef enum logic [2:0] {IDLE, PLAY, CRASH, WIN, LOSE} state_t;

    localparam logic [1:0] LIVES_INIT  = 2'(LIVES);
    localparam logic [7:0] CRASH_LAST  = 8'(CRASH_FRAMES - 1);
    localparam logic [7:0] RESULT_MAX  = 8'(RESULT_FRAMES);

    state_t     state, state_nxt;
    logic [7:0] frame_cnt, cnt_nxt;
    logic [1:0] lives_nxt;
    logic       new_game_nxt;
    logic       start_prev;
    logic       key_armed;
    logic       start_edge;

    // key_armed stays low until the key has been seen released after reset,
    // so a key held through reset cannot look like a fresh press.
    assign start_edge = startKey & ~start_prev & key_armed;

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = frame_cnt;
        lives_nxt    = livesLeft;
        new_game_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (start_edge) begin
                    state_nxt    = PLAY;
                    lives_nxt    = LIVES_INIT;
                    new_game_nxt = 1'b1;
                    cnt_nxt      = 8'd0;
                end
            end
            PLAY: begin
                if (finishLine) begin
                    state_nxt = WIN;
                    cnt_nxt   = 8'd0;
                end else if (fuelEmpty) begin
                    state_nxt = LOSE;
                    cnt_nxt   = 8'd0;
                end else if (crash) begin
                    cnt_nxt = 8'd0;
                    if (livesLeft <= 2'd1) begin
                        state_nxt = LOSE;
                        lives_nxt = 2'd0;
                    end else begin
                        state_nxt = CRASH;
                        lives_nxt = livesLeft - 2'd1;
                    end
                end
            end
            CRASH: begin
                if (fuelEmpty) begin
                    state_nxt = LOSE;
                    cnt_nxt   = 8'd0;
                end else if (startOfFrame) begin
                    if (frame_cnt == CRASH_LAST) begin
                        state_nxt = PLAY;
                        cnt_nxt   = 8'd0;
                    end else begin
                        cnt_nxt = frame_cnt + 8'd1;
                    end
                end
            end
            WIN, LOSE: begin
                // Early presses are dropped; the counter saturates at the hold length.
                if (start_edge && (frame_cnt == RESULT_MAX)) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 8'd0;
                end else if (startOfFrame && (frame_cnt != RESULT_MAX)) begin
                    cnt_nxt = frame_cnt + 8'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state       <= IDLE;
            frame_cnt   <= 8'd0;
            livesLeft   <= LIVES_INIT;
            start_prev  <= 1'b0;
            key_armed   <= 1'b0;
            gameReq     <= 1'b0;
            winReq      <= 1'b0;
            loseReq     <= 1'b0;
            crashFreeze <= 1'b0;
            newGame     <= 1'b0;
        end else begin
            state       <= state_nxt;
            frame_cnt   <= cnt_nxt;
            livesLeft   <= lives_nxt;
            start_prev  <= startKey;
            key_armed   <= key_armed | ~startKey;
            gameReq     <= (state_nxt == PLAY) || (state_nxt == CRASH);
            winReq      <= (state_nxt == WIN);
            loseReq     <= (state_nxt == LOSE);
            crashFreeze <= (state_nxt == CRASH);
            newGame     <= new_game_nxt;
        end
    end

endmodule

// File: tb/tb_game_state_controller.sv
module tb_game_state_controller;

    logic       clk = 1'b0;
    logic       resetN;
    logic       startOfFrame, startKey, crash, finishLine, fuelEmpty;
    logic       gameReq, winReq, loseReq, crashFreeze, newGame;
    logic [1:0] livesLeft;

    int vecs = 0;
    int errs = 0;

    game_state_controller #(
        .LIVES(3), .CRASH_FRAMES(4), .RESULT_FRAMES(3)
    ) dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
        .startKey(startKey), .crash(crash), .finishLine(finishLine),
        .fuelEmpty(fuelEmpty), .gameReq(gameReq), .winReq(winReq),
        .loseReq(loseReq), .crashFreeze(crashFreeze), .newGame(newGame),
        .livesLeft(livesLeft)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic frame();
        startOfFrame = 1'b1;
        cyc();
        startOfFrame = 1'b0;
        cyc();
    endtask

    initial begin
        resetN = 1'b0; startOfFrame = 1'b0; startKey = 1'b0;
        crash = 1'b0; finishLine = 1'b0; fuelEmpty = 1'b0;
        #12;
        chk("rst_game", gameReq, 0);
        chk("rst_win", winReq, 0);
        chk("rst_lose", loseReq, 0);
        chk("rst_freeze", crashFreeze, 0);
        chk("rst_newgame", newGame, 0);
        chk("rst_lives", livesLeft, 3);
        resetN = 1'b1;
        cyc();

        // start a game
        startKey = 1'b1; cyc();
        chk("start_game", gameReq, 1);
        chk("start_newgame", newGame, 1);
        chk("start_lives", livesLeft, 3);
        chk("start_win", winReq, 0);
        chk("start_lose", loseReq, 0);
        startKey = 1'b0; cyc();
        chk("newgame_pulse", newGame, 0);
        chk("play_game", gameReq, 1);

        // non-fatal crash
        crash = 1'b1; cyc(); crash = 1'b0;
        chk("crash1_lives", livesLeft, 2);
        chk("crash1_freeze", crashFreeze, 1);
        chk("crash1_game", gameReq, 1);
        crash = 1'b1; cyc(); crash = 1'b0;
        chk("crash_ignored_lives", livesLeft, 2);
        for (int i = 0; i < 3; i++) frame();
        chk("crash_3frames", crashFreeze, 1);
        frame();
        chk("crash_done_freeze", crashFreeze, 0);
        chk("crash_done_game", gameReq, 1);

        // second crash, then fatal third
        crash = 1'b1; cyc(); crash = 1'b0;
        chk("crash2_lives", livesLeft, 1);
        chk("crash2_freeze", crashFreeze, 1);
        for (int i = 0; i < 4; i++) frame();
        chk("crash2_done", crashFreeze, 0);
        crash = 1'b1; cyc(); crash = 1'b0;
        chk("fatal_lose", loseReq, 1);
        chk("fatal_game", gameReq, 0);
        chk("fatal_lives", livesLeft, 0);
        chk("fatal_freeze", crashFreeze, 0);

        // leave LOSE after the hold
        for (int i = 0; i < 3; i++) frame();
        startKey = 1'b1; cyc();
        chk("lose_exit_lose", loseReq, 0);
        chk("lose_exit_game", gameReq, 0);
        chk("idle_lives_kept", livesLeft, 0);
        startKey = 1'b0; cyc();

        // new game, finishLine beats crash
        startKey = 1'b1; cyc(); startKey = 1'b0;
        chk("game2_newgame", newGame, 1);
        chk("game2_lives", livesLeft, 3);
        cyc();
        finishLine = 1'b1; crash = 1'b1; cyc();
        finishLine = 1'b0; crash = 1'b0;
        chk("finish_win", winReq, 1);
        chk("finish_game", gameReq, 0);
        chk("finish_lives", livesLeft, 3);

        // WIN hold: early press dropped, held key never an edge
        frame();
        startKey = 1'b1; cyc();
        chk("early_press_win", winReq, 1);
        for (int i = 0; i < 3; i++) frame();
        chk("held_key_win", winReq, 1);
        startKey = 1'b0; cyc();
        chk("released_win", winReq, 1);
        startKey = 1'b1; cyc();
        chk("win_exit_win", winReq, 0);
        chk("win_exit_game", gameReq, 0);
        chk("win_exit_lose", loseReq, 0);
        chk("win_exit_freeze", crashFreeze, 0);
        startKey = 1'b0; cyc();

        // fuel runs out during CRASH
        startKey = 1'b1; cyc(); startKey = 1'b0;
        chk("game3_newgame", newGame, 1);
        cyc();
        crash = 1'b1; cyc(); crash = 1'b0;
        chk("game3_crash_lives", livesLeft, 2);
        fuelEmpty = 1'b1; cyc(); fuelEmpty = 1'b0;
        chk("fuel_lose", loseReq, 1);
        chk("fuel_game", gameReq, 0);
        chk("fuel_freeze", crashFreeze, 0);

        // fresh reset, then reset asserted mid-PLAY
        #2 resetN = 1'b0;
        #2 resetN = 1'b1;
        cyc();
        startKey = 1'b1; cyc(); startKey = 1'b0;
        chk("game4_game", gameReq, 1);
        crash = 1'b1; cyc(); crash = 1'b0;
        for (int i = 0; i < 4; i++) frame();
        chk("game4_play_lives", livesLeft, 2);
        chk("game4_play_game", gameReq, 1);
        #2 resetN = 1'b0;
        #1;
        chk("midrst_game", gameReq, 0);
        chk("midrst_win", winReq, 0);
        chk("midrst_lose", loseReq, 0);
        chk("midrst_lives", livesLeft, 3);

        // key held through reset must not start a game
        startKey = 1'b1;
        cyc();
        resetN = 1'b1;
        cyc(); cyc(); cyc();
        chk("held_thru_reset_game", gameReq, 0);
        chk("held_thru_reset_newgame", newGame, 0);
        startKey = 1'b0; cyc();
        startKey = 1'b1; cyc(); startKey = 1'b0;
        chk("after_release_game", gameReq, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
